onn_neuron_bank_ctrl: RTL and testbench

Parametrised N-neuron oscillatory neuron bank with a built-in run controller. It is the next generation of the fixed 15-neuron bank: neuron count and phase width are parameters, and the block adds load/run sequencing, per-period relative-phase snapshots, change detection, convergence detection and a timeout. It sits between the coupling network, which drives `nin` from `nout`, and the host/readout logic, which loads initial phases and reads `phi_out` after `done`.

---
 rtl/onn_pkg.sv | 21 ++
 rtl/onn_phase_neuron.sv | 89 ++++++++
 rtl/onn_neuron_bank_ctrl.sv | 151 +++++++++++++++
 tb/tb_onn_neuron_bank_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/onn_pkg.sv
// Shared types and defaults for the oscillatory neuron bank.
package onn_pkg;

  localparam int unsigned DEF_N_NEURONS      = 15;
  localparam int unsigned DEF_PHASE_W        = 4;
  localparam int unsigned DEF_STABLE_PERIODS = 4;
  localparam int unsigned DEF_MAX_PERIODS    = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } onn_state_e;

  // LSB position of neuron idx inside a packed phase vector
  function automatic int unsigned phase_lsb(input int unsigned idx, input int unsigned phase_w);
    return idx * phase_w;
  endfunction

endpackage

// File: rtl/onn_phase_neuron.sv
// One phase oscillator: phase register, coupling edge detect, advance/retard
// and per-period relative-phase snapshot with change flag.
module onn_phase_neuron import onn_pkg::*; #(
  parameter int unsigned PHASE_W = DEF_PHASE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
  input  logic               tick,
  input  logic [PHASE_W-1:0] ref_cnt,
  input  logic [PHASE_W-1:0] init_phase,
  input  logic               nin,
  output logic               nout,
  output logic [PHASE_W-1:0] phi_out,
  output logic               changed,
  output logic               changed_c
);

  localparam int unsigned MSB = PHASE_W - 1;

  logic [PHASE_W-1:0] phi_q, phi_d;
  logic [PHASE_W-1:0] prev_q, prev_d;
  logic [PHASE_W-1:0] phi_out_q, phi_out_d;
  logic               changed_q, changed_d;
  logic               nin_s_q, nin_s_d;
  logic               nin_d_q, nin_d_d;
  logic               nout_q, nout_d;
  logic               rise_c;
  logic [PHASE_W-1:0] rel_c;
  logic [PHASE_W-1:0] step_c;

  // nin is captured first, so an edge seen at one clock steers the next phase update
  always_comb begin
    rise_c    = nin_s_q & ~nin_d_q;
    rel_c     = phi_q - ref_cnt;
    changed_c = (rel_c != prev_q);
    step_c    = PHASE_W'(1);
    if (rise_c && phi_q[MSB]) begin
      step_c = PHASE_W'(2);
    end else if (rise_c && (phi_q != '0)) begin
      step_c = '0;
    end

    phi_d     = phi_q;
    prev_d    = prev_q;
    phi_out_d = phi_out_q;
    changed_d = changed_q;
    nin_s_d   = nin;
    nin_d_d   = nin_s_q;
    nout_d    = ~phi_q[MSB];
    if (load) begin
      phi_d  = init_phase;
      prev_d = init_phase;
    end else if (run) begin
      phi_d = phi_q + step_c;
      if (tick) begin
        phi_out_d = rel_c;
        prev_d    = rel_c;
        changed_d = changed_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phi_q     <= '0;
      prev_q    <= '0;
      phi_out_q <= '0;
      changed_q <= 1'b0;
      nin_s_q   <= 1'b0;
      nin_d_q   <= 1'b0;
      nout_q    <= 1'b1;
    end else begin
      phi_q     <= phi_d;
      prev_q    <= prev_d;
      phi_out_q <= phi_out_d;
      changed_q <= changed_d;
      nin_s_q   <= nin_s_d;
      nin_d_q   <= nin_d_d;
      nout_q    <= nout_d;
    end
  end

  assign nout    = nout_q;
  assign phi_out = phi_out_q;
  assign changed = changed_q;

endmodule

// File: rtl/onn_neuron_bank_ctrl.sv
// N-neuron oscillatory bank with load/run sequencing, convergence and timeout.
module onn_neuron_bank_ctrl import onn_pkg::*; #(
  parameter int unsigned N_NEURONS      = DEF_N_NEURONS,
  parameter int unsigned PHASE_W        = DEF_PHASE_W,
  parameter int unsigned STABLE_PERIODS = DEF_STABLE_PERIODS,
  parameter int unsigned MAX_PERIODS    = DEF_MAX_PERIODS
) (
  input  logic                           sclk,
  input  logic                           re_n,
  input  logic                           start,
  input  logic                           drop,
  input  logic [N_NEURONS-1:0]           nin,
  input  logic [N_NEURONS*PHASE_W-1:0]   state,
  output logic [N_NEURONS-1:0]           nout,
  output logic [N_NEURONS*PHASE_W-1:0]   phi_out,
  output logic [N_NEURONS-1:0]           state_changed,
  output logic                           busy,
  output logic                           done,
  output logic                           converged,
  output logic                           timeout
);

  localparam int unsigned PERIOD_W = $clog2(MAX_PERIODS + 1);
  localparam int unsigned STABLE_W = $clog2(STABLE_PERIODS + 1);

  onn_state_e          state_q, state_d;
  logic [PHASE_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                converged_q, converged_d;
  logic                timeout_q, timeout_d;

  logic                load_c, run_c, tick_c;
  logic [N_NEURONS-1:0] changed_c;
  logic [STABLE_W-1:0] stable_next;
  logic [PERIOD_W-1:0] period_next;
  logic                conv_hit, tmo_hit;

  // drop freezes the neurons on the very edge it is sampled
  always_comb begin
    load_c      = (state_q == ST_LOAD) && !drop;
    run_c       = (state_q == ST_RUN) && !drop;
    tick_c      = run_c && (ref_cnt_q == '1);
    stable_next = stable_cnt_q;
    if (|changed_c) begin
      stable_next = '0;
    end else if (stable_cnt_q != STABLE_W'(STABLE_PERIODS)) begin
      stable_next = stable_cnt_q + STABLE_W'(1);
    end
    period_next = period_cnt_q + PERIOD_W'(1);
    conv_hit    = tick_c && (stable_next == STABLE_W'(STABLE_PERIODS));
    tmo_hit     = tick_c && (period_next == PERIOD_W'(MAX_PERIODS));
  end

  always_comb begin
    state_d     = state_q;
    converged_d = converged_q;
    timeout_d   = timeout_q;
    if (drop) begin
      state_d     = ST_IDLE;
      converged_d = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d     = ST_LOAD;
          converged_d = 1'b0;
          timeout_d   = 1'b0;
        end
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (conv_hit) begin
            state_d     = ST_DONE;
            converged_d = 1'b1;
          end else if (tmo_hit) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  always_comb begin
    ref_cnt_d    = ref_cnt_q;
    period_cnt_d = period_cnt_q;
    stable_cnt_d = stable_cnt_q;
    if (load_c) begin
      ref_cnt_d    = '0;
      period_cnt_d = '0;
      stable_cnt_d = '0;
    end else if (run_c) begin
      ref_cnt_d = ref_cnt_q + PHASE_W'(1);
      if (tick_c) begin
        period_cnt_d = period_next;
        stable_cnt_d = stable_next;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!re_n) begin
      state_q      <= ST_IDLE;
      ref_cnt_q    <= '0;
      period_cnt_q <= '0;
      stable_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      converged_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_cnt_q    <= ref_cnt_d;
      period_cnt_q <= period_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      converged_q  <= converged_d;
      timeout_q    <= timeout_d;
    end
  end

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    onn_phase_neuron #(.PHASE_W(PHASE_W)) u_neuron (
      .clk        (sclk),
      .rst_n      (re_n),
      .load       (load_c),
      .run        (run_c),
      .tick       (tick_c),
      .ref_cnt    (ref_cnt_q),
      .init_phase (state[phase_lsb(i, PHASE_W) +: PHASE_W]),
      .nin        (nin[i]),
      .nout       (nout[i]),
      .phi_out    (phi_out[phase_lsb(i, PHASE_W) +: PHASE_W]),
      .changed    (state_changed[i]),
      .changed_c  (changed_c[i])
    );
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = converged_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_onn_neuron_bank_ctrl.sv
// Directed bench for onn_neuron_bank_ctrl: 3 neurons, 4-bit phase, STABLE=2, MAX=3.
module tb_onn_neuron_bank_ctrl;

  logic        sclk;
  logic        re_n;
  logic        start;
  logic        drop;
  logic [2:0]  nin;
  logic [11:0] state_in;
  logic [2:0]  nout;
  logic [11:0] phi_out;
  logic [2:0]  state_changed;
  logic        busy;
  logic        done;
  logic        converged;
  logic        timeout;

  int vectors;
  int miscompares;

  onn_neuron_bank_ctrl #(
    .N_NEURONS      (3),
    .PHASE_W        (4),
    .STABLE_PERIODS (2),
    .MAX_PERIODS    (3)
  ) u_dut (
    .sclk          (sclk),
    .re_n          (re_n),
    .start         (start),
    .drop          (drop),
    .nin           (nin),
    .state         (state_in),
    .nout          (nout),
    .phi_out       (phi_out),
    .state_changed (state_changed),
    .busy          (busy),
    .done          (done),
    .converged     (converged),
    .timeout       (timeout)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic step(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic go_idle();
    drop = 1'b1; start = 1'b0; nin = 3'b000;
    step(1);
    drop = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    re_n = 1'b0; start = 1'b0; drop = 1'b0; nin = 3'b000; state_in = 12'h000;
    step(2);
    vectors++; if (nout !== 3'b111) begin miscompares++; $display("FAIL reset_nout got %b exp 111", nout); end
    vectors++; if (phi_out !== 12'h000) begin miscompares++; $display("FAIL reset_phi_out got %h exp 000", phi_out); end
    vectors++; if (state_changed !== 3'b000) begin miscompares++; $display("FAIL reset_changed got %b exp 000", state_changed); end
    vectors++; if ({busy, done, converged, timeout} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", {busy, done, converged, timeout}); end
    re_n = 1'b1;
    step(1);
  endtask

  // phases {3,7,12}, no coupling: change-free, converges after 2 periods
  task automatic test_uncoupled();
    state_in = 12'hC73; start = 1'b1;
    step(1);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy got %b exp 1", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL load_done got %b exp 0", done); end
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL run_start_busy got %b exp 1", busy); end
    step(12);
    vectors++; if (phi_out !== 12'h000) begin miscompares++; $display("FAIL pre_tick_phi_out got %h exp 000", phi_out); end
    step(1);
    vectors++; if (phi_out !== 12'hC73) begin miscompares++; $display("FAIL tick1_phi_out got %h exp c73", phi_out); end
    vectors++; if (state_changed !== 3'b000) begin miscompares++; $display("FAIL tick1_changed got %b exp 000", state_changed); end
    step(15);
    vectors++; if ({done, busy} !== 2'b01) begin miscompares++; $display("FAIL run32_done_busy got %b exp 01", {done, busy}); end
    step(1);
    vectors++; if ({done, converged, timeout, busy} !== 4'b1100) begin miscompares++; $display("FAIL conv_flags got %b exp 1100", {done, converged, timeout, busy}); end
    vectors++; if (phi_out !== 12'hC73) begin miscompares++; $display("FAIL conv_phi_out got %h exp c73", phi_out); end
    vectors++; if (state_changed !== 3'b000) begin miscompares++; $display("FAIL conv_changed got %b exp 000", state_changed); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    vectors++; if ({done, converged, busy} !== 3'b010) begin miscompares++; $display("FAIL done_start_ignored got %b exp 010", {done, converged, busy}); end
    vectors++; if (nout !== 3'b011) begin miscompares++; $display("FAIL done_nout got %b exp 011", nout); end
  endtask

  task automatic test_drop_reload();
    drop = 1'b1;
    step(1);
    drop = 1'b0;
    vectors++; if ({converged, busy, done} !== 3'b000) begin miscompares++; $display("FAIL drop_done_flags got %b exp 000", {converged, busy, done}); end
    start = 1'b1; drop = 1'b1;
    step(1);
    start = 1'b0; drop = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_drop_busy got %b exp 0", busy); end
    step(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_drop_busy2 got %b exp 0", busy); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    vectors++; if ({busy, converged, timeout} !== 3'b100) begin miscompares++; $display("FAIL reload_flags got %b exp 100", {busy, converged, timeout}); end
    go_idle();
  endtask

  // one rise in RUN cycle 1 with phases {9,5,0}: advance, retard, plain step;
  // convergence and timeout coincide on tick 3 and convergence wins
  task automatic test_advance_retard();
    state_in = 12'h059; start = 1'b1;
    step(1);
    start = 1'b0; nin = 3'b111;
    step(16);
    step(1);
    vectors++; if (phi_out !== 12'h04A) begin miscompares++; $display("FAIL adv_tick1_phi_out got %h exp 04a", phi_out); end
    vectors++; if (state_changed !== 3'b011) begin miscompares++; $display("FAIL adv_tick1_changed got %b exp 011", state_changed); end
    step(16);
    vectors++; if (phi_out !== 12'h04A) begin miscompares++; $display("FAIL adv_tick2_phi_out got %h exp 04a", phi_out); end
    vectors++; if (state_changed !== 3'b000) begin miscompares++; $display("FAIL adv_tick2_changed got %b exp 000", state_changed); end
    step(15);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL adv_run48_done got %b exp 0", done); end
    step(1);
    vectors++; if ({done, converged, timeout} !== 3'b110) begin miscompares++; $display("FAIL tie_flags got %b exp 110", {done, converged, timeout}); end
    go_idle();
  endtask

  // neuron 0 starts at 9 and gets a rise every period, so rel drifts 10,11,12
  task automatic test_timeout();
    state_in = 12'h009; start = 1'b1;
    step(1);
    start = 1'b0; nin = 3'b001;
    step(1);
    for (int k = 1; k <= 48; k++) begin
      nin = ((k % 16) == 0) ? 3'b001 : 3'b000;
      if (k == 17) begin
        vectors++; if ({phi_out, state_changed} !== {12'h00A, 3'b001}) begin miscompares++; $display("FAIL tmo_tick1 got %h/%b exp 00a/001", phi_out, state_changed); end
      end
      if (k == 33) begin
        vectors++; if ({phi_out, state_changed} !== {12'h00B, 3'b001}) begin miscompares++; $display("FAIL tmo_tick2 got %h/%b exp 00b/001", phi_out, state_changed); end
      end
      step(1);
    end
    vectors++; if ({done, converged, timeout, busy} !== 4'b1010) begin miscompares++; $display("FAIL tmo_flags got %b exp 1010", {done, converged, timeout, busy}); end
    vectors++; if ({phi_out, state_changed} !== {12'h00C, 3'b001}) begin miscompares++; $display("FAIL tmo_tick3 got %h/%b exp 00c/001", phi_out, state_changed); end
    go_idle();
  endtask

  task automatic test_drop_mid_run();
    state_in = 12'hC73; start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    drop = 1'b1;
    step(1);
    drop = 1'b0;
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL drop_run_flags got %b exp 00", {busy, done}); end
    for (int k = 0; k < 3; k++) begin
      step(1);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL drop_run_no_done got %b exp 0", done); end
    end
    vectors++; if (nout !== 3'b101) begin miscompares++; $display("FAIL drop_frozen_nout got %b exp 101", nout); end
    vectors++; if (phi_out !== 12'h00C) begin miscompares++; $display("FAIL drop_phi_out_kept got %h exp 00c", phi_out); end
  endtask

  task automatic test_reset_mid_run();
    state_in = 12'hC73; start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);
    vectors++; if (phi_out !== 12'hC73) begin miscompares++; $display("FAIL rst_pre_phi_out got %h exp c73", phi_out); end
    re_n = 1'b0;
    step(1);
    vectors++; if ({nout, phi_out, state_changed} !== {3'b111, 12'h000, 3'b000}) begin miscompares++; $display("FAIL rst_run_data got %b/%h/%b exp 111/000/000", nout, phi_out, state_changed); end
    vectors++; if ({busy, done, converged, timeout} !== 4'b0000) begin miscompares++; $display("FAIL rst_run_flags got %b exp 0000", {busy, done, converged, timeout}); end
    re_n = 1'b1;
    step(1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    re_n = 1'b0; start = 1'b0; drop = 1'b0; nin = 3'b000; state_in = 12'h000;
    test_reset();
    test_uncoupled();
    test_drop_reload();
    test_advance_retard();
    test_timeout();
    test_drop_mid_run();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
